// File: rtl/uart_recv_if.sv
// uart_recv_if: configuration, serial input and received-word outputs of the UART receiver.
// master drives config and the line; slave is the receiver.
interface uart_recv_if;
  logic [2:0]  bps_mode;
  logic [3:0]  data_num;
  logic [1:0]  check_mode;
  logic [1:0]  stop_num;
  logic        rx_en;
  logic        uart_rxd;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        rx_busy;

  modport master (
    output bps_mode, data_num, check_mode, stop_num, rx_en, uart_rxd,
    input  rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  bps_mode, data_num, check_mode, stop_num, rx_en, uart_rxd,
    output rx_data, rx_valid, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_recv.sv
// uart_recv: UART receiver with per-frame latched framing config, parity and stop checks.
// Optional define UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote around the bit mid-point.
module uart_recv #(
  parameter int CLK_FREQ = 50000000
) (
  input logic        clk,
  input logic        rstn,
  uart_recv_if.slave bus
);
  localparam int DIV_0 = CLK_FREQ / 96 / 100;
  localparam int DIV_1 = CLK_FREQ / 192 / 100;
  localparam int DIV_2 = CLK_FREQ / 384 / 100;
  localparam int DIV_3 = CLK_FREQ / 1152 / 100;
  localparam int DIV_4 = CLK_FREQ / 2304 / 100;
  localparam int DIV_5 = CLK_FREQ / 4608 / 100;
  localparam int DIV_6 = CLK_FREQ / 9216 / 100;
  localparam int DIV_W = $clog2(DIV_0 + 2);

  typedef logic [DIV_W-1:0] cnt_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      r_state, w_nxt;
  logic        r_rxd_s1, r_rxd_s, r_rxd_d;
  logic [2:0]  r_bps;
  logic [3:0]  r_dnum;
  logic [1:0]  r_chk, r_snum;
  cnt_t        r_tcnt, w_div, w_mid;
  logic [3:0]  r_bcnt;
  logic [15:0] r_shreg;
  logic        r_perr, r_ferr;
  logic        r_valid, r_perr_o, r_ferr_o;
  logic [15:0] r_data;
  logic        w_start, w_done, w_tick, w_bit, w_par_exp;
  logic [15:0] w_mask, w_word;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s  <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= bus.uart_rxd;
      r_rxd_s  <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s;
    end
  end

  always_comb begin
    w_div = cnt_t'(DIV_0);
    case (r_bps)
      3'd1:    w_div = cnt_t'(DIV_1);
      3'd2:    w_div = cnt_t'(DIV_2);
      3'd3:    w_div = cnt_t'(DIV_3);
      3'd4:    w_div = cnt_t'(DIV_4);
      3'd5:    w_div = cnt_t'(DIV_5);
      3'd6:    w_div = cnt_t'(DIV_6);
      default: w_div = cnt_t'(DIV_0);
    endcase
  end
  assign w_mid = w_div >> 1;

`ifdef UART_RX_MAJORITY_EN
  logic r_smp_a, r_smp_b, w_vote_en;
  assign w_vote_en = (w_div >= cnt_t'(2));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_smp_a <= 1'b1;
      r_smp_b <= 1'b1;
    end else begin
      if (r_tcnt == w_mid - cnt_t'(1)) r_smp_a <= r_rxd_s;
      if (r_tcnt == w_mid)             r_smp_b <= r_rxd_s;
    end
  end

  // Decide at mid+1 once all three samples exist; tiny divisors fall back to mid.
  assign w_tick = (r_state != S_IDLE) &&
                  (r_tcnt == (w_vote_en ? w_mid + cnt_t'(1) : w_mid));
  assign w_bit  = w_vote_en ? ((r_smp_a & r_smp_b) | (r_smp_a & r_rxd_s) | (r_smp_b & r_rxd_s))
                            : r_rxd_s;
`else
  assign w_tick = (r_state != S_IDLE) && (r_tcnt == w_mid);
  assign w_bit  = r_rxd_s;
`endif

  assign w_mask    = 16'((32'd2 << r_dnum) - 32'd1);
  assign w_word    = r_shreg & w_mask;
  assign w_par_exp = (r_chk == 2'b01) ? ~^w_word : ^w_word;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_en && r_rxd_d && !r_rxd_s) begin
          w_nxt   = S_START;
          w_start = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) w_nxt = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_tick && (r_bcnt == r_dnum))
          w_nxt = (r_chk[0] ^ r_chk[1]) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_tick) w_nxt = S_STOP;
      end
      S_STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (w_tick && (r_bcnt == {2'b00, r_snum})) begin
          w_nxt  = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bps    <= '0;
      r_dnum   <= '0;
      r_chk    <= '0;
      r_snum   <= '0;
      r_tcnt   <= '0;
      r_bcnt   <= '0;
      r_shreg  <= '0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
    end else begin
      if (w_start) begin
        r_bps   <= bus.bps_mode;
        r_dnum  <= bus.data_num;
        r_chk   <= bus.check_mode;
        r_snum  <= bus.stop_num;
        r_tcnt  <= '0;
        r_bcnt  <= '0;
        r_shreg <= '0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_tcnt <= (r_tcnt == w_div) ? '0 : r_tcnt + cnt_t'(1);
      end

      if (w_tick) begin
        case (r_state)
          S_DATA: begin
            r_shreg <= {r_shreg[14:0], w_bit};
            r_bcnt  <= (r_bcnt == r_dnum) ? '0 : r_bcnt + 4'd1;
          end
          S_PARITY: r_perr <= (w_bit != w_par_exp);
          S_STOP: begin
            if (!w_bit) r_ferr <= 1'b1;
            r_bcnt <= r_bcnt + 4'd1;
          end
          default: ;
        endcase
      end

      r_valid <= w_done;
      if (w_done) begin
        r_data   <= w_word;
        r_perr_o <= r_perr;
        r_ferr_o <= r_ferr | ~w_bit;
      end
    end
  end

  assign bus.rx_valid   = r_valid;
  assign bus.rx_data    = r_data;
  assign bus.parity_err = r_perr_o;
  assign bus.frame_err  = r_ferr_o;
  assign bus.rx_busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed frames with hand-computed words/flags for uart_recv at 50 MHz.
module tb_uart_recv;
  localparam int CLK_FREQ = 50000000;
  localparam int P6 = 55;   // 50e6/9216/100 = 54 -> 55 clocks per bit
  localparam int P3 = 435;  // 50e6/1152/100 = 434 -> 435 clocks per bit

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  uart_recv_if u_if();

  uart_recv #(.CLK_FREQ(CLK_FREQ)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int vcnt = 0;
  int v_t_prev = 0;
  int v_t_last = 0;
  int v_long = 0;
  logic        v_q = 1'b0;
  logic [15:0] v_d_prev = '0;
  logic [15:0] v_d_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    v_q <= u_if.rx_valid;
    if (u_if.rx_valid) begin
      vcnt     <= vcnt + 1;
      v_t_prev <= v_t_last;
      v_t_last <= cyc;
      v_d_prev <= v_d_last;
      v_d_last <= u_if.rx_data;
      if (v_q) v_long <= v_long + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] bps, input logic [3:0] dn, input logic [1:0] ck,
                     input logic [1:0] sn);
    u_if.bps_mode   = bps;
    u_if.data_num   = dn;
    u_if.check_mode = ck;
    u_if.stop_num   = sn;
  endtask

  task automatic idle(input int n);
    u_if.uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Start bit, data MSB first, optional parity (par<0 = none), stop bits from stopv[0..ns-1].
  task automatic send(input logic [15:0] w, input int nb, input int par, input int ns,
                      input logic [3:0] stopv, input int p);
    u_if.uart_rxd = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = nb - 1; i >= 0; i--) begin
      u_if.uart_rxd = w[i];
      repeat (p) @(negedge clk);
    end
    if (par >= 0) begin
      u_if.uart_rxd = par[0];
      repeat (p) @(negedge clk);
    end
    for (int i = 0; i < ns; i++) begin
      u_if.uart_rxd = stopv[i];
      repeat (p) @(negedge clk);
    end
  endtask

  initial begin
    int v0;
    int bc;
    u_if.uart_rxd = 1'b1;
    u_if.rx_en    = 1'b1;
    cfg(3'd6, 4'd7, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(u_if.rx_valid), 0);
    chk("rst_data", 32'(u_if.rx_data), 0);
    chk("rst_busy", 32'(u_if.rx_busy), 0);
    chk("rst_perr", 32'(u_if.parity_err), 0);
    chk("rst_ferr", 32'(u_if.frame_err), 0);
    rstn = 1'b1;
    idle(5);

    // basic 8N1
    v0 = vcnt;
    send(16'h00A5, 8, -1, 1, 4'b0001, P6);
    idle(10);
    chk("t1_cnt", 32'(vcnt - v0), 1);
    chk("t1_data", 32'(u_if.rx_data), 32'h00A5);
    chk("t1_perr", 32'(u_if.parity_err), 0);
    chk("t1_ferr", 32'(u_if.frame_err), 0);
    chk("t1_busy", 32'(u_if.rx_busy), 0);

    // parity
    cfg(3'd6, 4'd15, 2'b01, 2'b00);
    send(16'h8001, 16, 1, 1, 4'b0001, P6);
    idle(10);
    chk("odd_ok_data", 32'(u_if.rx_data), 32'h8001);
    chk("odd_ok_perr", 32'(u_if.parity_err), 0);
    send(16'h8001, 16, 0, 1, 4'b0001, P6);
    idle(10);
    chk("odd_bad_perr", 32'(u_if.parity_err), 1);
    cfg(3'd6, 4'd15, 2'b10, 2'b00);
    send(16'h0003, 16, 0, 1, 4'b0001, P6);
    idle(10);
    chk("even_ok_data", 32'(u_if.rx_data), 32'h0003);
    chk("even_ok_perr", 32'(u_if.parity_err), 0);

    // narrow words: upper bits must read zero
    cfg(3'd6, 4'd0, 2'b00, 2'b00);
    send(16'h0001, 1, -1, 1, 4'b0001, P6);
    idle(10);
    chk("w1_data", 32'(u_if.rx_data), 32'h0001);
    cfg(3'd6, 4'd3, 2'b00, 2'b00);
    send(16'h000B, 4, -1, 1, 4'b0001, P6);
    idle(10);
    chk("w4_data", 32'(u_if.rx_data), 32'h000B);

    // framing: third of four stop bits low
    cfg(3'd6, 4'd7, 2'b00, 2'b11);
    send(16'h005A, 8, -1, 4, 4'b1011, P6);
    idle(10);
    chk("fe_data", 32'(u_if.rx_data), 32'h005A);
    chk("fe_ferr", 32'(u_if.frame_err), 1);
    chk("fe_perr", 32'(u_if.parity_err), 0);

    // break: last stop low, line stays low
    v0 = vcnt;
    send(16'h005A, 8, -1, 4, 4'b0111, P6);
    repeat (3 * P6) @(negedge clk);
    chk("brk_cnt", 32'(vcnt - v0), 1);
    chk("brk_ferr", 32'(u_if.frame_err), 1);
    chk("brk_busy", 32'(u_if.rx_busy), 0);
    idle(2 * P6);
    chk("brk_high_cnt", 32'(vcnt - v0), 1);
    cfg(3'd6, 4'd7, 2'b00, 2'b00);
    send(16'h0033, 8, -1, 1, 4'b0001, P6);
    idle(10);
    chk("brk_after_cnt", 32'(vcnt - v0), 2);
    chk("brk_after_data", 32'(u_if.rx_data), 32'h0033);
    chk("brk_after_ferr", 32'(u_if.frame_err), 0);

    // false start: 10-cycle low glitch
    v0 = vcnt;
    bc = 0;
    u_if.uart_rxd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) u_if.uart_rxd = 1'b1;
      @(negedge clk);
      if (u_if.rx_busy) bc++;
    end
    chk("fs_cnt", 32'(vcnt - v0), 0);
    chk("fs_busy_seen", 32'(bc > 0), 1);
    chk("fs_busy_short", 32'(bc <= 30), 1);

`ifdef UART_RX_MAJORITY_EN
    // one-cycle high glitch on data bit 4 at its sample point must be voted out
    u_if.uart_rxd = 1'b0;
    repeat (P6) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      u_if.uart_rxd = 1'b0;
      if (i == 4) begin
        repeat (28) @(negedge clk);
        u_if.uart_rxd = 1'b1;
        @(negedge clk);
        u_if.uart_rxd = 1'b0;
        repeat (P6 - 29) @(negedge clk);
      end else begin
        repeat (P6) @(negedge clk);
      end
    end
    idle(P6 + 10);
    chk("maj_data", 32'(u_if.rx_data), 32'h0000);
`endif

    // back-to-back, rx_en dropped during the second frame
    v0 = vcnt;
    send(16'h0001, 8, -1, 1, 4'b0001, P6);
    fork
      send(16'h00FE, 8, -1, 1, 4'b0001, P6);
      begin
        repeat (5 * P6) @(negedge clk);
        u_if.rx_en = 1'b0;
      end
    join
    idle(10);
    chk("b2b_cnt", 32'(vcnt - v0), 2);
    chk("b2b_data0", 32'(v_d_prev), 32'h0001);
    chk("b2b_data1", 32'(v_d_last), 32'h00FE);
    chk("b2b_gap", 32'(v_t_last - v_t_prev), 32'(10 * P6));
    v0 = vcnt;
    send(16'h0077, 8, -1, 1, 4'b0001, P6);
    idle(10);
    chk("dis_cnt", 32'(vcnt - v0), 0);
    chk("dis_data", 32'(u_if.rx_data), 32'h00FE);
    u_if.rx_en = 1'b1;

    // reset in the middle of DATA
    u_if.uart_rxd = 1'b0;
    repeat (3 * P6) @(negedge clk);
    chk("mr_busy_pre", 32'(u_if.rx_busy), 1);
    rstn = 1'b0;
    #1;
    chk("mr_busy", 32'(u_if.rx_busy), 0);
    chk("mr_data", 32'(u_if.rx_data), 0);
    u_if.uart_rxd = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    idle(5);
    v0 = vcnt;
    cfg(3'd3, 4'd7, 2'b00, 2'b00);
    send(16'h003C, 8, -1, 1, 4'b0001, P3);
    idle(10);
    chk("mr_after_cnt", 32'(vcnt - v0), 1);
    chk("mr_after_data", 32'(u_if.rx_data), 32'h003C);
    chk("mr_after_ferr", 32'(u_if.frame_err), 0);

    chk("valid_1cyc", 32'(v_long), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
